// File: rtl/memtrace_pkg.sv
// Shared types and widths for the memory-trace lane sequencer.
// Field widths track the trace-source widths so captured beats stay consistent.
package memtrace_pkg;

  localparam int MT_ADDR_W = 64;
  localparam int MT_DATA_W = 64;
  localparam int MT_MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } mt_state_e;

  typedef struct packed {
    logic [MT_ADDR_W-1:0] address;
    logic                 is_store;
    logic [MT_MASK_W-1:0] store_mask;
    logic [MT_DATA_W-1:0] data;
  } mt_lane_req_t;

endpackage

// File: rtl/memtrace_lane_sequencer_prio.sv
// Lowest-set-bit encoder: index, one-hot and any-set flag of a request vector.
module lane_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Scan downward so the lowest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

  assign onehot = req & (~req + N'(1));
  assign any    = |req;

endmodule

// File: rtl/memtrace_lane_sequencer.sv
// Captures one multi-lane trace beat and issues its active lanes in ascending
// order over a single valid/ready request port, then reports end-of-trace.
module memtrace_lane_sequencer
  import memtrace_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = MT_ADDR_W,
  parameter int DATA_W    = MT_DATA_W,
  parameter int MASK_W    = MT_MASK_W
) (
  input  logic                                          clock,
  input  logic                                          reset,
  output logic                                          in_ready,
  input  logic [NUM_LANES-1:0]                          in_valid,
  input  logic [NUM_LANES*ADDR_W-1:0]                   in_address,
  input  logic [NUM_LANES-1:0]                          in_is_store,
  input  logic [NUM_LANES*MASK_W-1:0]                   in_store_mask,
  input  logic [NUM_LANES*DATA_W-1:0]                   in_data,
  input  logic                                          in_finished,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] out_lane,
  output logic [ADDR_W-1:0]                             out_address,
  output logic                                          out_is_store,
  output logic [MASK_W-1:0]                             out_store_mask,
  output logic [DATA_W-1:0]                             out_data,
  output logic                                          done,
  output logic [31:0]                                   issued_count
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  mt_state_e            state_q, state_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic                 finPend_q, finPend_d;
  logic [31:0]          count_q, count_d;
  mt_lane_req_t         beat_q [NUM_LANES];
  mt_lane_req_t         laneIn [NUM_LANES];
  mt_lane_req_t         selEntry;
  logic                 accept;
  logic [LANE_W-1:0]    sel;
  logic [NUM_LANES-1:0] selOnehot;
  logic                 selAny;
  logic                 lastLane;

  lane_prio_enc #(
    .N(NUM_LANES),
    .W(LANE_W)
  ) uPrio (
    .req   (pending_q),
    .idx   (sel),
    .onehot(selOnehot),
    .any   (selAny)
  );

  assign lastLane = ~|(pending_q & ~selOnehot);
  assign selEntry = beat_q[sel];

  always_comb begin
    for (int g = 0; g < NUM_LANES; g++) begin
      laneIn[g].address    = MT_ADDR_W'(in_address[g*ADDR_W +: ADDR_W]);
      laneIn[g].is_store   = in_is_store[g];
      laneIn[g].store_mask = MT_MASK_W'(in_store_mask[g*MASK_W +: MASK_W]);
      laneIn[g].data       = MT_DATA_W'(in_data[g*DATA_W +: DATA_W]);
    end
  end

  // A beat is taken whole in IDLE; DRAIN retires one lane per handshake.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    finPend_d = finPend_q;
    count_d   = count_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          accept    = 1'b1;
          pending_d = in_valid;
          finPend_d = in_finished;
          state_d   = DRAIN;
        end else if (in_finished) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (out_ready && selAny) begin
          pending_d = pending_q & ~selOnehot;
          count_d   = count_q + 32'd1;
          if (lastLane) state_d = finPend_q ? DONE : IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state_q == IDLE) && !reset;
    out_valid      = 1'b0;
    out_lane       = '0;
    out_address    = '0;
    out_is_store   = 1'b0;
    out_store_mask = '0;
    out_data       = '0;
    if (state_q == DRAIN) begin
      out_valid    = 1'b1;
      out_lane     = sel;
      out_address  = ADDR_W'(selEntry.address);
      out_is_store = selEntry.is_store;
      out_data     = DATA_W'(selEntry.data);
      if (selEntry.is_store) out_store_mask = MASK_W'(selEntry.store_mask);
    end
  end

  assign done         = (state_q == DONE);
  assign issued_count = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      finPend_q <= 1'b0;
      count_q   <= '0;
      for (int g = 0; g < NUM_LANES; g++) beat_q[g] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      finPend_q <= finPend_d;
      count_q   <= count_d;
      if (accept) begin
        for (int g = 0; g < NUM_LANES; g++) beat_q[g] <= laneIn[g];
      end
    end
  end

endmodule

// File: tb/tb_memtrace_lane_sequencer.sv
// Bench for memtrace_lane_sequencer: table of beats checked through a scoreboard,
// plus hand sequences for stall, finish and reset corners.
module tb_memtrace_lane_sequencer;

  localparam int NL = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int LW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_ready;
  logic [NL-1:0]    in_valid;
  logic [NL*AW-1:0] in_address;
  logic [NL-1:0]    in_is_store;
  logic [NL*MW-1:0] in_store_mask;
  logic [NL*DW-1:0] in_data;
  logic             in_finished;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    out_lane;
  logic [AW-1:0]    out_address;
  logic             out_is_store;
  logic [MW-1:0]    out_store_mask;
  logic [DW-1:0]    out_data;
  logic             done;
  logic [31:0]      issued_count;

  memtrace_lane_sequencer dut (
    .clock(clock), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_address(in_address), .in_is_store(in_is_store), .in_store_mask(in_store_mask),
    .in_data(in_data), .in_finished(in_finished), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane(out_lane), .out_address(out_address),
    .out_is_store(out_is_store), .out_store_mask(out_store_mask), .out_data(out_data),
    .done(done), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [LW-1:0] lane;
    logic [AW-1:0] addr;
    logic          st;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [NL-1:0]    valid;
    logic [NL-1:0]    st;
    logic [NL*AW-1:0] addr;
    logic [NL*MW-1:0] mask;
    logic [NL*DW-1:0] data;
  } beat_t;

  exp_t        expQ[$];
  beat_t       vec[5];
  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expCount    = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected request.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious issue", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_lane", out_lane, e.lane);
        checkOutput("out_address", out_address, e.addr);
        checkOutput("out_is_store", out_is_store, e.st);
        checkOutput("out_store_mask", out_store_mask, e.mask);
        checkOutput("out_data", out_data, e.data);
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(posedge clock); #1;
    end
    if (!in_ready) checkOutput("in_ready wait", in_ready, 1'b1);
  endtask

  // Drives one beat for a single accept edge and predicts its issue order.
  task automatic applyStimulus(input beat_t b, input logic fin);
    exp_t e;
    waitReady();
    in_valid      = b.valid;
    in_is_store   = b.st;
    in_address    = b.addr;
    in_store_mask = b.mask;
    in_data       = b.data;
    in_finished   = fin;
    for (int g = 0; g < NL; g++) begin
      if (b.valid[g]) begin
        e.lane = LW'(g);
        e.addr = b.addr[g*AW +: AW];
        e.st   = b.st[g];
        e.mask = b.st[g] ? b.mask[g*MW +: MW] : '0;
        e.data = b.data[g*DW +: DW];
        expQ.push_back(e);
        expCount++;
      end
    end
    @(posedge clock); #1;
    in_valid    = '0;
    in_finished = 1'b0;
  endtask

  task automatic holdReset();
    reset = 1'b1;
    expQ.delete();
    expCount = 0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int low;
    beat_t b;
    reset = 1'b1; in_valid = '0; in_address = '0; in_is_store = '0;
    in_store_mask = '0; in_data = '0; in_finished = 1'b0; out_ready = 1'b1;

    vec[0] = '{4'b1011, 4'b0000, {64'h400, 64'h300, 64'h200, 64'h100},
               {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {64'h33, 64'h22, 64'h11, 64'h00}};
    vec[1] = '{4'b0101, 4'b0100, {64'hA3, 64'hA2, 64'hA1, 64'hA0},
               {8'h00, 8'hF0, 8'h00, 8'hFF}, {64'h0, 64'hDEADBEEF, 64'h0, 64'h1234}};
    vec[2] = '{4'b0001, 4'b0001, {64'h0, 64'h0, 64'h0, 64'hFFFF_0000_0000_0040},
               {8'h00, 8'h00, 8'h00, 8'h3C}, {64'h0, 64'h0, 64'h0, 64'hCAFE}};
    vec[3] = '{4'b1111, 4'b1010, {64'h7000, 64'h6000, 64'h5000, 64'h4000},
               {8'h81, 8'h42, 8'h24, 8'h18}, {64'hD3, 64'hD2, 64'hD1, 64'hD0}};
    vec[4] = '{4'b1000, 4'b0111, {64'hBEEF, 64'h999, 64'h888, 64'h777},
               {8'h0F, 8'hEE, 8'hDD, 8'hCC}, {64'h44, 64'h99, 64'h88, 64'h77}};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset in_ready", in_ready, 1'b0);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset issued_count", issued_count, 32'd0);
    checkOutput("reset out_address", out_address, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle in_ready", in_ready, 1'b1);

    // Table of beats with out_ready held high.
    foreach (vec[i]) begin
      applyStimulus(vec[i], 1'b0);
      low = 0;
      while (!in_ready && low < 50) begin
        low++;
        @(posedge clock); #1;
      end
      checkOutput($sformatf("vec%0d in_ready low cycles", i), low, $countones(vec[i].valid));
      checkOutput($sformatf("vec%0d issued_count", i), issued_count, expCount);
      checkOutput($sformatf("vec%0d scoreboard empty", i), expQ.size(), 0);
    end

    // Stall: presented request must stay put while out_ready is low.
    out_ready = 1'b0;
    b = '{4'b0110, 4'b0000, {64'h0, 64'h2222, 64'h1111, 64'h0}, '0, '0};
    applyStimulus(b, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall out_valid", out_valid, 1'b1);
      checkOutput("stall out_lane", out_lane, 2'd1);
      checkOutput("stall out_address", out_address, 64'h1111);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    waitReady();
    checkOutput("stall drained", expQ.size(), 0);
    checkOutput("stall issued_count", issued_count, expCount);

    // Finish together with a beat: lane issues, then done.
    b = '{4'b1000, 4'b0000, {64'h3333, 64'h0, 64'h0, 64'h0}, '0, '0};
    applyStimulus(b, 1'b1);
    checkOutput("finbeat out_valid", out_valid, 1'b1);
    checkOutput("finbeat out_lane", out_lane, 2'd3);
    checkOutput("finbeat done early", done, 1'b0);
    @(posedge clock); #1;
    checkOutput("finbeat done", done, 1'b1);
    checkOutput("finbeat in_ready", in_ready, 1'b0);
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput("done ignores out_valid", out_valid, 1'b0);
      checkOutput("done sticky", done, 1'b1);
      checkOutput("done in_ready", in_ready, 1'b0);
    end
    in_valid = '0;
    checkOutput("finbeat scoreboard", expQ.size(), 0);

    // Finish while idle.
    holdReset();
    reset = 1'b0;
    in_finished = 1'b1;
    @(posedge clock); #1;
    in_finished = 1'b0;
    checkOutput("idlefin done", done, 1'b1);
    checkOutput("idlefin out_valid", out_valid, 1'b0);
    @(posedge clock); #1;
    checkOutput("idlefin out_valid later", out_valid, 1'b0);

    // Reset mid-drain after one of four lanes issued.
    holdReset();
    reset = 1'b0;
    applyStimulus(vec[3], 1'b0);
    @(posedge clock); #1;
    checkOutput("middrain one issued", issued_count, 32'd1);
    reset = 1'b1;
    expQ.delete();
    @(posedge clock); #1;
    checkOutput("middrain out_valid", out_valid, 1'b0);
    checkOutput("middrain issued_count", issued_count, 32'd0);
    checkOutput("middrain in_ready", in_ready, 1'b0);
    reset = 1'b0;
    expCount = 0;
    applyStimulus(vec[0], 1'b0);
    waitReady();
    checkOutput("postreset issued_count", issued_count, 32'd3);
    checkOutput("postreset scoreboard", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
